// File: rtl/pipelined_rip_adder_if.sv
// Operand/result bundle for pipelined_rip_adder. OVF is present only when
// PIPELINED_RIP_ADDER_OVF_EN is defined.
interface pipelined_rip_adder_if #(
  parameter int WIDTH = 16
);
  logic             IN_VALID;
  logic             IN_READY;
  logic             SUB;
  logic             CIN;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [WIDTH-1:0] SUM;
  logic             COUT;
`ifdef PIPELINED_RIP_ADDER_OVF_EN
  logic             OVF;
`endif

  // Valid/ready: a beat transfers on a rising CK where valid and ready are both
  // high; a source holding valid keeps its payload stable until that edge, and
  // ready never depends on valid.
  modport master (
    output IN_VALID, SUB, CIN, A, B, OUT_READY,
    input  IN_READY, OUT_VALID, SUM, COUT
`ifdef PIPELINED_RIP_ADDER_OVF_EN
    , input OVF
`endif
  );

  modport slave (
    input  IN_VALID, SUB, CIN, A, B, OUT_READY,
    output IN_READY, OUT_VALID, SUM, COUT
`ifdef PIPELINED_RIP_ADDER_OVF_EN
    , output OVF
`endif
  );
endinterface

// File: rtl/pipelined_rip_adder.sv
// WIDTH-bit add/subtract split into WIDTH/SEG ripple segments with registered
// inter-segment carries; optional OVF output via PIPELINED_RIP_ADDER_OVF_EN.
module pipelined_rip_adder #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input logic                  CK,
  input logic                  RST,
  pipelined_rip_adder_if.slave bus
);
  localparam int NSEG = WIDTH / SEG;
  localparam int LAST = NSEG - 1;

  logic adv;

  // The whole pipeline moves together: any stall at the output freezes every stage.
  assign adv          = !bus.OUT_VALID || bus.OUT_READY;
  assign bus.IN_READY = adv;

  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    // Stage k keeps only the operand segments not yet summed and the result
    // segments already produced, so each beat's data narrows/widens as it moves.
    localparam int OW = WIDTH - k * SEG;
    localparam int RW = (k + 1) * SEG;

    logic          vld;
    logic          carry;
    logic [OW-1:0] a;
    logic [OW-1:0] b;
    logic [SEG:0]  seg_sum;
    logic [RW-1:0] r_out;

    assign seg_sum = {1'b0, a[SEG-1:0]} + {1'b0, b[SEG-1:0]} + {{SEG{1'b0}}, carry};

    if (k == 0) begin : g_in
      assign r_out = seg_sum[SEG-1:0];

      always_ff @(posedge CK) begin
        if (!RST) begin
          vld   <= 1'b0;
          carry <= 1'b0;
          a     <= '0;
          b     <= '0;
        end else if (adv) begin
          vld   <= bus.IN_VALID;
          carry <= bus.CIN ^ bus.SUB;
          a     <= bus.A;
          b     <= bus.B ^ {WIDTH{bus.SUB}};
        end
      end
    end else begin : g_link
      logic [RW-SEG-1:0] r;

      assign r_out = {seg_sum[SEG-1:0], r};

      always_ff @(posedge CK) begin
        if (!RST) begin
          vld   <= 1'b0;
          carry <= 1'b0;
          a     <= '0;
          b     <= '0;
          r     <= '0;
        end else if (adv) begin
          vld   <= g_seg[k-1].vld;
          carry <= g_seg[k-1].seg_sum[SEG];
          a     <= g_seg[k-1].a[OW+SEG-1:SEG];
          b     <= g_seg[k-1].b[OW+SEG-1:SEG];
          r     <= g_seg[k-1].r_out;
        end
      end
    end
  end

`ifdef PIPELINED_RIP_ADDER_OVF_EN
  logic msb_cin;

  // Sum bit = a ^ b ^ carry-in, so the carry into the MSB falls out of the last stage.
  assign msb_cin = g_seg[LAST].seg_sum[SEG-1] ^ g_seg[LAST].a[SEG-1] ^ g_seg[LAST].b[SEG-1];
`endif

  // Result registers only load on a real beat; bubbles leave the last value visible.
  always_ff @(posedge CK) begin
    if (!RST) begin
      bus.OUT_VALID <= 1'b0;
      bus.SUM       <= '0;
      bus.COUT      <= 1'b0;
`ifdef PIPELINED_RIP_ADDER_OVF_EN
      bus.OVF       <= 1'b0;
`endif
    end else if (adv) begin
      bus.OUT_VALID <= g_seg[LAST].vld;
      if (g_seg[LAST].vld) begin
        bus.SUM  <= g_seg[LAST].r_out;
        bus.COUT <= g_seg[LAST].seg_sum[SEG];
`ifdef PIPELINED_RIP_ADDER_OVF_EN
        bus.OVF  <= msb_cin ^ g_seg[LAST].seg_sum[SEG];
`endif
      end
    end
  end
endmodule

// File: tb/tb_pipelined_rip_adder.sv
// Bench for pipelined_rip_adder: a 16/4 instance and an 8/8 (single-stage) instance,
// each checked against an arithmetic reference and latency/handshake rules.
module tb_pipelined_rip_adder;
  localparam int NSEG  = 4;
  localparam int NSEG8 = 1;
`ifdef PIPELINED_RIP_ADDER_OVF_EN
  localparam int EW = 18;
`else
  localparam int EW = 17;
`endif

  logic CK;
  logic RST;
  logic RST8;

  pipelined_rip_adder_if #(.WIDTH(16)) bus ();
  pipelined_rip_adder_if #(.WIDTH(8))  bus8 ();

  pipelined_rip_adder #(.WIDTH(16), .SEG(4)) dut  (.CK(CK), .RST(RST),  .bus(bus));
  pipelined_rip_adder #(.WIDTH(8),  .SEG(8)) dut8 (.CK(CK), .RST(RST8), .bus(bus8));

  int checks   = 0;
  int failures = 0;

  // ---------------- clock / reset ----------------
  initial CK = 1'b0;
  always #5 CK = ~CK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference models ----------------
  function automatic logic [EW-1:0] model16(input logic [15:0] a, input logic [15:0] b,
                                            input logic sub, input logic cin);
    logic [16:0] r;
    int          sa, sb, sres;
    logic        ovf;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (!sub) begin
      r    = {1'b0, a} + {1'b0, b} + 17'(cin);
      sres = sa + sb + int'(cin);
    end else begin
      r[15:0] = a - b - 16'(cin);
      r[16]   = (int'(a) >= int'(b) + int'(cin));
      sres    = sa - sb - int'(cin);
    end
    ovf = (sres > 32767) || (sres < -32768);
`ifdef PIPELINED_RIP_ADDER_OVF_EN
    return {ovf, r};
`else
    if (ovf) return r;
    return r;
`endif
  endfunction

  function automatic logic [8:0] model8(input logic [7:0] a, input logic [7:0] b,
                                        input logic sub, input logic cin);
    if (!sub) return {1'b0, a} + {1'b0, b} + 9'(cin);
    return {(int'(a) >= int'(b) + int'(cin)), 8'(a - b - 8'(cin))};
  endfunction

  // ---------------- scoreboard, 16/4 instance ----------------
  logic [EW-1:0] exp_q[$];
  int            acc_cyc_q[$];
  int            acc_stall_q[$];
  int            cyc = 0;
  int            stall_cnt = 0;
  logic          rst_prev = 1'b0;
  logic          pv = 1'b0, pr = 1'b0, pc = 1'b0;
  logic [15:0]   ps = '0;
  logic [EW-1:0] act_v, exp_v;
  int            t_acc, s_acc;

  always @(negedge CK) begin
    cyc++;
    if (!RST) begin
      exp_q.delete();
      acc_cyc_q.delete();
      acc_stall_q.delete();
      rst_prev = 1'b1;
    end else begin
      if (rst_prev) begin
        check("reset_out_valid", 32'(bus.OUT_VALID), 0);
        check("reset_sum", 32'(bus.SUM), 0);
        check("reset_cout", 32'(bus.COUT), 0);
        check("reset_in_ready", 32'(bus.IN_READY), 1);
      end else begin
        if (pv && !pr) begin
          check("stall_hold_valid", 32'(bus.OUT_VALID), 1);
          check("stall_hold_sum", 32'(bus.SUM), 32'(ps));
          check("stall_hold_cout", 32'(bus.COUT), 32'(pc));
        end
        if (!bus.OUT_VALID) begin
          check("idle_keep_sum", 32'(bus.SUM), 32'(ps));
          check("idle_keep_cout", 32'(bus.COUT), 32'(pc));
        end
      end
      check("in_ready_rule", 32'(bus.IN_READY), 32'(!bus.OUT_VALID || bus.OUT_READY));
      if (bus.IN_VALID && bus.IN_READY) begin
        exp_q.push_back(model16(bus.A, bus.B, bus.SUB, bus.CIN));
        acc_cyc_q.push_back(cyc);
        acc_stall_q.push_back(stall_cnt);
      end
      if (bus.OUT_VALID && bus.OUT_READY) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 32'(bus.SUM), 32'hFFFF_FFFF);
        end else begin
          exp_v = exp_q.pop_front();
          t_acc = acc_cyc_q.pop_front();
          s_acc = acc_stall_q.pop_front();
`ifdef PIPELINED_RIP_ADDER_OVF_EN
          act_v = {bus.OVF, bus.COUT, bus.SUM};
`else
          act_v = {bus.COUT, bus.SUM};
`endif
          check("result", 32'(act_v), 32'(exp_v));
          check("latency", cyc - t_acc, NSEG + 1 + stall_cnt - s_acc);
        end
      end
      if (bus.OUT_VALID && !bus.OUT_READY) stall_cnt++;
      rst_prev = 1'b0;
    end
    pv = bus.OUT_VALID;
    pr = bus.OUT_READY;
    ps = bus.SUM;
    pc = bus.COUT;
  end

  // ---------------- scoreboard, 8/8 instance ----------------
  logic [8:0] exp8_q[$];
  int         acc8_q[$];
  logic       rst8_prev = 1'b0;
  logic [8:0] exp8_v;
  int         t8;

  always @(negedge CK) begin
    if (!RST8) begin
      exp8_q.delete();
      acc8_q.delete();
      rst8_prev = 1'b1;
    end else begin
      if (rst8_prev) begin
        check("reset8_out_valid", 32'(bus8.OUT_VALID), 0);
        check("reset8_sum", 32'(bus8.SUM), 0);
        check("reset8_cout", 32'(bus8.COUT), 0);
        check("reset8_in_ready", 32'(bus8.IN_READY), 1);
      end
      check("in_ready8_rule", 32'(bus8.IN_READY), 32'(!bus8.OUT_VALID || bus8.OUT_READY));
      if (bus8.IN_VALID && bus8.IN_READY) begin
        exp8_q.push_back(model8(bus8.A, bus8.B, bus8.SUB, bus8.CIN));
        acc8_q.push_back(cyc);
      end
      if (bus8.OUT_VALID && bus8.OUT_READY) begin
        if (exp8_q.size() == 0) begin
          check("unexpected_beat8", 32'(bus8.SUM), 32'hFFFF_FFFF);
        end else begin
          exp8_v = exp8_q.pop_front();
          t8     = acc8_q.pop_front();
          check("result8", 32'({bus8.COUT, bus8.SUM}), 32'(exp8_v));
          check("latency8", cyc - t8, NSEG8 + 1);
        end
      end
      rst8_prev = 1'b0;
    end
  end

  // ---------------- drivers ----------------
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic sub,
                      input logic cin, output int waits);
    logic acc;
    waits = 0;
    acc   = 1'b0;
    bus.A = a; bus.B = b; bus.SUB = sub; bus.CIN = cin; bus.IN_VALID = 1'b1;
    while (!acc) begin
      @(negedge CK);
      acc = bus.IN_READY;
      @(posedge CK); #1;
      if (!acc) begin
        waits++;
        if (waits > 200) begin
          check("send_timeout", 32'(waits), 0);
          acc = 1'b1;
        end
      end
    end
    bus.IN_VALID = 1'b0;
  endtask

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic sub, input logic cin);
    int waits;
    logic acc;
    waits  = 0;
    acc    = 1'b0;
    bus8.A = a; bus8.B = b; bus8.SUB = sub; bus8.CIN = cin; bus8.IN_VALID = 1'b1;
    while (!acc) begin
      @(negedge CK);
      acc = bus8.IN_READY;
      @(posedge CK); #1;
      if (!acc) begin
        waits++;
        if (waits > 200) begin
          check("send8_timeout", 32'(waits), 0);
          acc = 1'b1;
        end
      end
    end
    bus8.IN_VALID = 1'b0;
  endtask

  // One beat into an empty pipeline; pins latency and the literal result.
  task automatic run_single(input string name, input logic [15:0] a, input logic [15:0] b,
                            input logic sub, input logic cin, input logic [16:0] exp,
                            input logic exp_ovf);
    int w;
    int lat;
    bus.OUT_READY = 1'b1;
    send(a, b, sub, cin, w);
    lat = 0;
    while (lat < 20) begin
      @(negedge CK);
      if (bus.OUT_VALID) break;
      @(posedge CK); #1;
      lat++;
    end
    check({name, "_latency"}, lat, NSEG);
    check({name, "_sum_cout"}, 32'({bus.COUT, bus.SUM}), 32'(exp));
`ifdef PIPELINED_RIP_ADDER_OVF_EN
    check({name, "_ovf"}, 32'(bus.OVF), 32'(exp_ovf));
`else
    if (exp_ovf !== exp_ovf) check({name, "_ovf_arg"}, 0, 1);
`endif
    @(posedge CK); #1;
  endtask

  // ---------------- main sequence ----------------
  logic [EW-1:0] m;
  int            w, w_total, n_out, stall0, gap, lat8;
  int            idx_q[$];
  logic [15:0]   sum_q[$];
  logic          rnd_done;

  initial begin
    RST = 1'b0; RST8 = 1'b0;
    bus.IN_VALID = 1'b0; bus.OUT_READY = 1'b1; bus.A = '0; bus.B = '0; bus.SUB = 1'b0; bus.CIN = 1'b0;
    bus8.IN_VALID = 1'b0; bus8.OUT_READY = 1'b1; bus8.A = '0; bus8.B = '0; bus8.SUB = 1'b0; bus8.CIN = 1'b0;
    repeat (2) @(posedge CK);
    #1;
    RST = 1'b1; RST8 = 1'b1;
    @(posedge CK); #1;

    // Pin the reference model with hand-computed values.
    m = model16(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    check("pin_model_carry", 32'(m[16:0]), 32'h1_0000);
    m = model16(16'h0005, 16'h0007, 1'b1, 1'b0);
    check("pin_model_sub_borrow", 32'(m[16:0]), 32'h0_FFFE);
    m = model16(16'h0007, 16'h0005, 1'b1, 1'b0);
    check("pin_model_sub", 32'(m[16:0]), 32'h1_0002);
    m = model16(16'h1234, 16'h0001, 1'b1, 1'b1);
    check("pin_model_sub_bin", 32'(m[16:0]), 32'h1_1232);
`ifdef PIPELINED_RIP_ADDER_OVF_EN
    m = model16(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    check("pin_model_ovf_add", 32'(m), 32'h2_8000);
    m = model16(16'h8000, 16'h0001, 1'b1, 1'b0);
    check("pin_model_ovf_sub", 32'(m), 32'h3_7FFF);
`endif

    // Directed beats with literal expectations.
    run_single("full_carry", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 17'h1_0000, 1'b0);
    run_single("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b0, 17'h0_FFFE, 1'b0);
    run_single("sub_plain",  16'h0007, 16'h0005, 1'b1, 1'b0, 17'h1_0002, 1'b0);
    run_single("add_cin",    16'h00FF, 16'h0F00, 1'b0, 1'b1, 17'h0_1000, 1'b0);
    run_single("ovf_add",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 17'h0_8000, 1'b1);
    run_single("ovf_sub",    16'h8000, 16'h0001, 1'b1, 1'b0, 17'h1_7FFF, 1'b1);
    run_single("no_ovf",     16'h0001, 16'h0001, 1'b0, 1'b0, 17'h0_0002, 1'b0);

    // Streaming: 8 back-to-back beats must exit on 8 consecutive cycles in order.
    w_total = 0;
    bus.OUT_READY = 1'b1;
    fork
      for (int i = 1; i <= 8; i++) begin
        send(16'(i), 16'(32'h1000 * i), 1'b0, 1'b0, w);
        w_total += w;
      end
      for (int c = 0; c < 24; c++) begin
        @(negedge CK);
        if (bus.OUT_VALID) begin
          idx_q.push_back(c);
          sum_q.push_back(bus.SUM);
        end
      end
    join
    @(posedge CK); #1;
    check("stream_no_wait", w_total, 0);
    check("stream_count", idx_q.size(), 8);
    if (idx_q.size() == 8) begin
      check("stream_consecutive", idx_q[7] - idx_q[0], 7);
      for (int i = 0; i < 8; i++) check("stream_sum", 32'(sum_q[i]), 32'h1001 * (i + 1));
    end

    // Backpressure: OUT_READY low for cycles 5..9 of a 6-beat burst.
    stall0 = stall_cnt;
    fork
      for (int i = 0; i < 6; i++)
        send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), w);
      for (int c = 0; c < 15; c++) begin
        bus.OUT_READY = !(c >= 5 && c <= 9);
        @(posedge CK); #1;
      end
    join
    bus.OUT_READY = 1'b1;
    repeat (10) @(posedge CK);
    #1;
    check("bp_stalled", 32'(stall_cnt > stall0), 1);
    check("bp_drained", exp_q.size(), 0);

    // Reset with three beats in flight: nothing stale may emerge.
    for (int i = 0; i < 3; i++) send(16'($urandom), 16'($urandom), 1'b0, 1'b0, w);
    RST = 1'b0;
    @(posedge CK); #1;
    RST = 1'b1;
    n_out = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge CK);
      if (bus.OUT_VALID) n_out++;
    end
    @(posedge CK); #1;
    check("reset_no_stale", n_out, 0);

    // Single-stage instance: latency 1, carry, random stream, reset mid-flight.
    send8(8'hFF, 8'h01, 1'b0, 1'b0);
    lat8 = 0;
    while (lat8 < 10) begin
      @(negedge CK);
      if (bus8.OUT_VALID) break;
      @(posedge CK); #1;
      lat8++;
    end
    check("nseg1_latency", lat8, 1);
    check("nseg1_sum_cout", 32'({bus8.COUT, bus8.SUM}), 32'h100);
    @(posedge CK); #1;
    for (int i = 0; i < 20; i++)
      send8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    send8(8'h12, 8'h34, 1'b0, 1'b0);
    RST8 = 1'b0;
    @(posedge CK); #1;
    RST8 = 1'b1;
    n_out = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge CK);
      if (bus8.OUT_VALID) n_out++;
    end
    @(posedge CK); #1;
    check("nseg1_reset_no_stale", n_out, 0);

    // Randomized traffic with random gaps and random backpressure.
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          gap = $urandom_range(0, 2);
          for (int g = 0; g < gap; g++) begin
            @(posedge CK); #1;
          end
          send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), w);
        end
        rnd_done = 1'b1;
      end
      while (!rnd_done) begin
        bus.OUT_READY = ($urandom_range(0, 3) != 0);
        @(posedge CK); #1;
      end
    join
    bus.OUT_READY = 1'b1;
    repeat (12) @(posedge CK);
    #1;
    check("random_drained", exp_q.size(), 0);
    check("nseg1_drained", exp8_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipelined_rip_adder.md
Name: pipelined_rip_adder

Overview:
- Parametrised successor to the 4-bit clocked ripple adder.
- Splits a WIDTH-bit add/subtract into NSEG = WIDTH/SEG ripple segments. The carry between segments is registered.
- Operand and result skew registers deliver a complete, aligned sum NSEG cycles after acceptance.
- Adds a valid/ready handshake with full-pipeline stall and an add/subtract mode.
- Sits in the datapath wherever wide sums must close timing at CK rate.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of SEG.
SEG, 4, bits per pipeline segment; NSEG = WIDTH/SEG, minimum 1.

Ports:
CK  input  1  clock; all state updates on rising edge.
RST  input  1  reset; synchronous, active-low (0 = reset).
IN_VALID  input  1  operand beat present.
IN_READY  output  1  block accepts the beat this cycle.
SUB  input  1  0 = A+B+CIN, 1 = A-B with borrow-in CIN.
CIN  input  1  carry-in (add) or borrow-in (sub).
A  input  WIDTH  operand A.
B  input  WIDTH  operand B.
OUT_VALID  output  1  result beat present.
OUT_READY  input  1  downstream accepts the result.
SUM  output  WIDTH  result.
COUT  output  1  carry-out of the MSB segment.

Behaviour:
- Reset: all of the following clear to 0 on a CK edge with RST=0, overriding any handshake:
  - stage valid bits, carry registers, skew registers;
  - OUT_VALID, SUM, COUT.
  - IN_READY=1 in the cycle after reset deasserts.
  - A beat in flight during reset is discarded.
- Operand conditioning at acceptance:
  - Beff = B ^ {WIDTH{SUB}}
  - c0 = CIN ^ SUB
  - Subtraction with CIN=0 therefore gives A-B. COUT=1 means no borrow.
- Pipeline:
  - Stage k (0..NSEG-1) adds A[k*SEG +: SEG] + Beff[k*SEG +: SEG] + carry_k.
  - carry_0 = c0, captured at acceptance. carry_k for k>0 is the registered carry-out of stage k-1.
  - Operand segment k is delayed k cycles; result segment k is delayed NSEG-1-k cycles, so all segments of one beat exit together.
  - Each stage holds one valid bit, travelling with its data.
- Latency: a beat accepted at edge t appears with OUT_VALID=1 after edge t+NSEG (NSEG=4: visible in the 4th cycle after acceptance).
  - NSEG=1 degenerates to a single registered adder with latency 1.
- Handshake:
  - adv = !OUT_VALID | OUT_READY.
  - IN_READY = adv (combinational; no dependence on IN_VALID).
  - Accept occurs when IN_VALID & IN_READY.
  - When adv=1, every stage shifts one step. A bubble (valid=0) enters stage 0 when IN_VALID=0.
  - When adv=0, all stage, carry and skew registers hold. SUM, COUT and OUT_VALID stay stable until taken.
- Throughput: one beat per cycle while OUT_READY=1. Bubbles propagate and never merge.
- SUM and COUT update only on adv. With OUT_VALID=0 they retain the last value (0 after reset).
- Simultaneous output take and input accept in the same cycle is legal and loses no data.
- Wrap-around: SUM is modulo 2^WIDTH. The carry out of the MSB is reported only on COUT.
- IN_VALID=1 with IN_READY=0: the inputs are ignored, and the source must hold them.

Optional Feature:
- Macro: PIPELINED_RIP_ADDER_OVF_EN.
- Defined: adds output OVF (1 bit, reset 0), aligned with SUM/COUT.
  - OVF = carry into MSB XOR carry out of MSB, i.e. signed two's-complement overflow for both add and subtract.
  - The carry into the MSB is taken inside the last stage.
- Undefined: no OVF port and no related logic. All other behaviour is identical.

Test Plan:
All scenarios use WIDTH=16, SEG=4 unless stated.
- Full carry propagation: A=0xFFFF, B=0x0001, CIN=0, SUB=0, OUT_READY=1 -> OUT_VALID rises after 4 edges; SUM=0x0000, COUT=1.
- Subtraction: A=0x0005, B=0x0007, SUB=1, CIN=0 -> SUM=0xFFFE, COUT=0. A=0x0007, B=0x0005 -> SUM=0x0002, COUT=1.
- Streaming: 8 back-to-back beats, A=i, B=0x1000*i, i=1..8 -> 8 consecutive OUT_VALID cycles with SUM=0x1001*i in order, IN_READY=1 throughout.
- Backpressure: stream 6 beats with OUT_READY=0 for cycles 5..9 -> IN_READY=0 while OUT_VALID=1 and stalled; SUM/COUT stable; no beat lost or duplicated; order preserved after release.
- Reset mid-flight: 3 beats accepted, then RST=0 for 1 cycle -> next cycle OUT_VALID=0, SUM=0, COUT=0; no stale beat ever emerges. Repeat with WIDTH=8, SEG=8 (NSEG=1): latency 1.
- OVF (macro defined): A=0x7FFF+B=0x0001 -> OVF=1, SUM=0x8000. A=0x8000-B=0x0001 (SUB=1) -> OVF=1, SUM=0x7FFF. A=0x0001+B=0x0001 -> OVF=0.
